// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and shared memory bus of the arbiter
interface mem_arbiter_if #(
    parameter XLEN = 9'd64
);
    // fetch port
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ready;
    logic            if_error;

    // data port
    logic            d_read_req;
    logic            d_write_req;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [2:0]      d_size;
    logic [XLEN-1:0] d_rdata;
    logic            d_ready;
    logic            d_error;

    // shared memory bus
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [2:0]      bus_size;
    logic            bus_read;
    logic            bus_write;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ready;
    logic            bus_error;

    // arbiter side: owns the bus command and the per-port responses
    modport master (
        input  if_req, if_addr,
        input  d_read_req, d_write_req, d_addr, d_wdata, d_size,
        input  bus_rdata, bus_ready, bus_error,
        output if_rdata, if_ready, if_error,
        output d_rdata, d_ready, d_error,
        output bus_addr, bus_wdata, bus_size, bus_read, bus_write
    );

    // environment side: requesters and the memory
    modport slave (
        output if_req, if_addr,
        output d_read_req, d_write_req, d_addr, d_wdata, d_size,
        output bus_rdata, bus_ready, bus_error,
        input  if_rdata, if_ready, if_error,
        input  d_rdata, d_ready, d_error,
        input  bus_addr, bus_wdata, bus_size, bus_read, bus_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one memory bus with timeout
module mem_arbiter #(
    parameter XLEN    = 9'd64,
    parameter TIMEOUT = 16'd1024
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master arb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic            LAST_FETCH = 1'b0;
    localparam logic            LAST_DATA  = 1'b1;
    // counter value in the final allowed BUSY cycle; one more silent cycle is a timeout
    localparam logic [15:0]     CNT_LAST   = 16'(TIMEOUT - 2);
    localparam logic [XLEN-1:0] ZERO_WORD  = '0;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [15:0] cnt;

    logic        if_elig;
    logic        d_elig;
    logic        grant_if;
    logic        grant_d;
    logic        done_ok;
    logic        done_err;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // arbitration in IDLE, completion detection in BUSY_x
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        // a port whose response is showing this cycle must not be re-granted on the same request
        if_elig    = arb.if_req && !arb.if_ready && !arb.if_error;
        d_elig     = (arb.d_read_req || arb.d_write_req) && !arb.d_ready && !arb.d_error;
        case (state)
            IDLE: begin
                if (if_elig && d_elig) begin
                    if (last_grant == LAST_DATA) begin
                        grant_if = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else begin
                    grant_if = if_elig;
                    grant_d  = d_elig;
                end
                if (grant_if) begin
                    state_next = BUSY_IF;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (arb.bus_error) begin
                    done_err = 1'b1;
                end else if (arb.bus_ready) begin
                    done_ok = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    done_err = 1'b1;
                end
                if (done_ok || done_err) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // bus command latch, timeout counter and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            arb.bus_addr  <= ZERO_WORD;
            arb.bus_wdata <= ZERO_WORD;
            arb.bus_size  <= 3'd0;
            arb.bus_read  <= 1'b0;
            arb.bus_write <= 1'b0;
            arb.if_rdata  <= ZERO_WORD;
            arb.if_ready  <= 1'b0;
            arb.if_error  <= 1'b0;
            arb.d_rdata   <= ZERO_WORD;
            arb.d_ready   <= 1'b0;
            arb.d_error   <= 1'b0;
            last_grant    <= LAST_FETCH;
            cnt           <= 16'd0;
        end else begin
            arb.if_ready <= 1'b0;
            arb.if_error <= 1'b0;
            arb.d_ready  <= 1'b0;
            arb.d_error  <= 1'b0;
            if (grant_if) begin
                arb.bus_addr  <= arb.if_addr;
                arb.bus_wdata <= ZERO_WORD;
                arb.bus_size  <= 3'd2;
                arb.bus_read  <= 1'b1;
                arb.bus_write <= 1'b0;
                last_grant    <= LAST_FETCH;
                cnt           <= 16'd0;
            end else if (grant_d) begin
                arb.bus_addr  <= arb.d_addr;
                arb.bus_wdata <= arb.d_wdata;
                arb.bus_size  <= arb.d_size;
                arb.bus_read  <= !arb.d_write_req;
                arb.bus_write <= arb.d_write_req;
                last_grant    <= LAST_DATA;
                cnt           <= 16'd0;
            end else if (done_ok || done_err) begin
                arb.bus_read  <= 1'b0;
                arb.bus_write <= 1'b0;
                if (state == BUSY_IF) begin
                    if (done_ok) begin
                        arb.if_ready <= 1'b1;
                        arb.if_rdata <= arb.bus_rdata;
                    end else begin
                        arb.if_error <= 1'b1;
                    end
                end else begin
                    if (done_ok) begin
                        arb.d_ready <= 1'b1;
                        // stores leave the last load data visible
                        if (!arb.bus_write) begin
                            arb.d_rdata <= arb.bus_rdata;
                        end
                    end else begin
                        arb.d_error <= 1'b1;
                    end
                end
            end else if (state != IDLE) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule
